// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register byte offsets,
// STATUS bit positions and the TX/RX state machine encodings.
package uart_mmio_pkg;

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_RXDATA = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_VALID    = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_TX_IDLE     = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CLR,
        RX_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO buffering CPU stores for the UART transmitter.
// Ports: clk/rst, push/din (write), pop/dout (head, combinational), full, empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Same slot, opposite lap: the writer is a whole buffer ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped CPU front end for the UART: TXDATA/RXDATA/STATUS window,
// TX FIFO drained via data_in/wr_en paced by Tx_busy, RX capture with ready_clr.
// Ports: clk_50m, rst; CPU bus addr/wdata/we/re/rdata;
//        UART data_in/wr_en/Tx_busy (TX) and data_out/ready/ready_clr (RX).
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          BUSY_TIMEOUT = 15
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic [7:0]  data_in,
    output logic        wr_en,
    input  logic        Tx_busy,
    input  logic [7:0]  data_out,
    input  logic        ready,
    output logic        ready_clr
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    logic       sel;
    logic [3:0] off;
    logic       wr_tx;
    logic       wr_st;
    logic       rd_rx;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    tx_state_e  tx_state;
    tx_state_e  tx_next;
    logic [CW-1:0] busy_cnt;
    logic [CW-1:0] cnt_next;
    logic       load_byte;

    rx_state_e  rx_state;
    rx_state_e  rx_next;
    logic       capture;
    logic       ovr_set;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_overrun;
    logic       tx_overflow;
    logic       tx_idle;
    logic       ovf_set;
    logic [31:0] status;

    logic       unused_bits;

    assign sel   = (addr[31:4] == BASE_ADDR[31:4]);
    assign off   = {addr[3:2], 2'b00};
    assign wr_tx = sel && we && (off == REG_TXDATA);
    assign wr_st = sel && we && (off == REG_STATUS);
    assign rd_rx = sel && re && (off == REG_RXDATA);

    // Fullness is judged before any same-edge pop, so a push that meets
    // a full FIFO is dropped even while ISSUE is popping.
    assign fifo_push = wr_tx && !fifo_full;
    assign ovf_set   = wr_tx && fifo_full;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50m),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX state machine
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            busy_cnt <= '0;
            data_in  <= '0;
        end else begin
            tx_state <= tx_next;
            busy_cnt <= cnt_next;
            if (load_byte)
                data_in <= fifo_head;
        end
    end

    always_comb begin
        tx_next   = tx_state;
        cnt_next  = busy_cnt;
        fifo_pop  = 1'b0;
        load_byte = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty && !Tx_busy) begin
                    tx_next   = TX_ISSUE;
                    load_byte = 1'b1;
                end
            end
            TX_ISSUE: begin
                fifo_pop = 1'b1;
                cnt_next = '0;
                tx_next  = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                // A transmitter that never raises busy must not wedge
                // the queue; the byte is then treated as sent.
                if (Tx_busy)
                    tx_next = TX_WAIT_DONE;
                else if (busy_cnt == CW'(BUSY_TIMEOUT - 1))
                    tx_next = TX_IDLE;
                else
                    cnt_next = busy_cnt + CW'(1);
            end
            TX_WAIT_DONE: begin
                if (!Tx_busy)
                    tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    assign wr_en = (tx_state == TX_ISSUE);

    // RX state machine
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            ready_clr <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            ready_clr <= (rx_state == RX_CLR);
        end
    end

    always_comb begin
        rx_next = rx_state;
        capture = 1'b0;
        ovr_set = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (ready) begin
                    rx_next = RX_CLR;
                    // A same-edge RXDATA read frees the holding register.
                    if (!rx_valid || rd_rx)
                        capture = 1'b1;
                    else
                        ovr_set = 1'b1;
                end
            end
            RX_CLR: rx_next = RX_WAIT;
            RX_WAIT: begin
                if (!ready)
                    rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Holding register and sticky flags; a set beats a same-edge W1C.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (capture)
                rx_byte <= data_out;
            if (capture)
                rx_valid <= 1'b1;
            else if (rd_rx)
                rx_valid <= 1'b0;
            rx_overrun  <= ovr_set ||
                (rx_overrun && !(wr_st && wdata[ST_RX_OVERRUN]));
            tx_overflow <= ovf_set ||
                (tx_overflow && !(wr_st && wdata[ST_TX_OVERFLOW]));
        end
    end

    assign tx_idle = fifo_empty && (tx_state == TX_IDLE) && !Tx_busy;

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = fifo_full;
        status[ST_TX_EMPTY]    = fifo_empty;
        status[ST_RX_VALID]    = rx_valid;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_TX_OVERFLOW] = tx_overflow;
        status[ST_TX_IDLE]     = tx_idle;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (off)
                REG_RXDATA: rdata = {24'b0, rx_byte};
                REG_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

endmodule
